// File: rtl/n1_mem_arbiter.sv
// rtl/n1_mem_arbiter.sv - single-port RAM arbiter for host, fetch and data requesters
module n1_mem_arbiter #(
    parameter int RAM_WORDS    = 128,
    parameter int STARVE_LIMIT = 4,
    localparam int AW          = $clog2(RAM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          halt,
    input  logic          h_req,
    input  logic          f_req,
    input  logic          d_req,
    input  logic          h_we,
    input  logic          d_we,
    input  logic [AW-1:0] h_addr,
    input  logic [AW-1:0] f_addr,
    input  logic [AW-1:0] d_addr,
    input  logic [15:0]   h_wdata,
    input  logic [15:0]   d_wdata,
    output logic          h_gnt,
    output logic          f_gnt,
    output logic          d_gnt,
    output logic          h_rvalid,
    output logic          f_rvalid,
    output logic          d_rvalid,
    output logic [15:0]   rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_wdata,
    input  logic [15:0]   ram_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_HOST  = 2'd1,
        OWN_FETCH = 2'd2,
        OWN_DATA  = 2'd3
    } owner_t;

    owner_t     rsel, rsel_next;
    logic [3:0] starve_cnt, starve_next;
    logic       f_eff, d_eff, starve_hit;

    assign f_eff      = f_req & ~halt;
    assign d_eff      = d_req & ~halt;
    assign starve_hit = (starve_cnt == LIMIT);

    // Grants stay combinational so a winner transfers in the cycle it asks.
    always_comb begin
        h_gnt = 1'b0;
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (h_req)                   h_gnt = 1'b1;
            else if (f_eff && starve_hit) f_gnt = 1'b1;
            else if (d_eff)              d_gnt = 1'b1;
            else if (f_eff)              f_gnt = 1'b1;
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        rsel_next = OWN_NONE;
        if (h_gnt) begin
            ram_en    = 1'b1;
            ram_we    = h_we;
            ram_addr  = h_addr;
            ram_wdata = h_wdata;
            rsel_next = h_we ? OWN_NONE : OWN_HOST;
        end else if (f_gnt) begin
            ram_en    = 1'b1;
            ram_addr  = f_addr;
            rsel_next = OWN_FETCH;
        end else if (d_gnt) begin
            ram_en    = 1'b1;
            ram_we    = d_we;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
            rsel_next = d_we ? OWN_NONE : OWN_DATA;
        end
    end

    // Halt freezes the counter so fetch keeps its accumulated claim across a halt.
    always_comb begin
        starve_next = starve_cnt;
        if (!halt) begin
            if (f_gnt || !f_req)
                starve_next = 4'd0;
            else if (d_gnt && !starve_hit)
                starve_next = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsel       <= OWN_NONE;
            starve_cnt <= 4'd0;
        end else begin
            rsel       <= rsel_next;
            starve_cnt <= starve_next;
        end
    end

    assign h_rvalid = (rsel == OWN_HOST);
    assign f_rvalid = (rsel == OWN_FETCH);
    assign d_rvalid = (rsel == OWN_DATA);
    assign rdata    = ram_rdata;

endmodule

// File: tb/tb_n1_mem_arbiter.sv
// tb/tb_n1_mem_arbiter.sv - scoreboard bench for n1_mem_arbiter
module tb_n1_mem_arbiter;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          halt = 1'b0;
    logic          h_req = 1'b0, f_req = 1'b0, d_req = 1'b0;
    logic          h_we = 1'b0, d_we = 1'b0;
    logic [AW-1:0] h_addr = '0, f_addr = '0, d_addr = '0;
    logic [15:0]   h_wdata = '0, d_wdata = '0;
    logic          h_gnt, f_gnt, d_gnt;
    logic          h_rvalid, f_rvalid, d_rvalid;
    logic [15:0]   rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata = '0;

    logic [15:0]   mem [0:127];
    logic [17:0]   sb [$];
    int            vectors = 0;
    int            miscompares = 0;

    n1_mem_arbiter #(.RAM_WORDS(128), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .h_req(h_req), .f_req(f_req), .d_req(d_req),
        .h_we(h_we), .d_we(d_we),
        .h_addr(h_addr), .f_addr(f_addr), .d_addr(d_addr),
        .h_wdata(h_wdata), .d_wdata(d_wdata),
        .h_gnt(h_gnt), .f_gnt(f_gnt), .d_gnt(d_gnt),
        .h_rvalid(h_rvalid), .f_rvalid(f_rvalid), .d_rvalid(d_rvalid),
        .rdata(rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, read returns the old word
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= 16'h1001;
            mem[1] <= 16'h2002;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    // owner code: 1 host, 2 fetch, 3 data
    always @(negedge clk) begin
        if (rst_n && (h_rvalid || f_rvalid || d_rvalid)) begin
            logic [1:0]  own;
            logic [17:0] exp;
            own = h_rvalid ? 2'd1 : (f_rvalid ? 2'd2 : 2'd3);
            vectors++;
            if ($countones({h_rvalid, f_rvalid, d_rvalid}) != 1) begin
                miscompares++;
                $display("FAIL rvalid_onehot: got h/f/d=%b%b%b, required one-hot",
                         h_rvalid, f_rvalid, d_rvalid);
            end else if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL rvalid_unexpected: got owner %0d rdata %h, required no rvalid",
                         own, rdata);
            end else begin
                exp = sb.pop_front();
                if ({own, rdata} !== exp) begin
                    miscompares++;
                    $display("FAIL read_return: got owner %0d rdata %h, required owner %0d rdata %h",
                             own, rdata, exp[17:16], exp[15:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_gnt(input string name, input logic [2:0] exp);
        @(negedge clk);
        vectors++;
        if ({h_gnt, f_gnt, d_gnt} !== exp) begin
            miscompares++;
            $display("FAIL %s: got gnt h/f/d=%b, required %b", name, {h_gnt, f_gnt, d_gnt}, exp);
        end
    endtask

    task automatic cyc(input string name, input logic [2:0] exp);
        expect_gnt(name, exp);
        step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // expected grants for f_req & d_req held, with the read-returns they produce
    task automatic fd_run(input string name, input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            if (pat[i] == "d") begin
                sb.push_back({2'd3, 16'h2002});
                cyc(name, 3'b001);
            end else begin
                sb.push_back({2'd2, 16'h1001});
                cyc(name, 3'b010);
            end
        end
    endtask

    initial begin
        f_addr = 7'd0;
        d_addr = 7'd1;

        // reset state with requests pending
        h_req = 1'b1; f_req = 1'b1; d_req = 1'b1;
        #2;
        check("reset_gnt", {29'd0, h_gnt, f_gnt, d_gnt}, 32'd0);
        check("reset_rvalid", {29'd0, h_rvalid, f_rvalid, d_rvalid}, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // host write then read while halted
        halt = 1'b1; h_we = 1'b1; h_addr = 7'd5; h_wdata = 16'h1A2B;
        expect_gnt("host_write", 3'b100);
        check("host_write_ram", {8'd0, ram_en, ram_we, ram_addr, ram_wdata}, {8'd0, 1'b1, 1'b1, 7'd5, 16'h1A2B});
        step();
        h_we = 1'b0;
        sb.push_back({2'd1, 16'h1A2B});
        cyc("host_read", 3'b100);
        h_req = 1'b0; f_req = 1'b0; d_req = 1'b0; halt = 1'b0;
        expect_gnt("idle", 3'b000);
        check("idle_ram", {8'd0, ram_en, ram_we, ram_addr, ram_wdata}, 32'd0);
        step();

        // priority
        h_req = 1'b1; f_req = 1'b1; d_req = 1'b1;
        sb.push_back({2'd1, 16'h1A2B});
        cyc("prio_host", 3'b100);
        h_req = 1'b0;
        sb.push_back({2'd3, 16'h2002});
        cyc("prio_data", 3'b001);
        d_req = 1'b0;
        sb.push_back({2'd2, 16'h1001});
        cyc("prio_fetch", 3'b010);

        // read routing on consecutive cycles
        sb.push_back({2'd2, 16'h1001});
        cyc("route_fetch", 3'b010);
        f_req = 1'b0; d_req = 1'b1;
        sb.push_back({2'd3, 16'h2002});
        cyc("route_data", 3'b001);
        d_req = 1'b0;
        cyc("idle2", 3'b000);

        // starvation guard
        f_req = 1'b1; d_req = 1'b1;
        fd_run("starve", "ddddfddddf");
        f_req = 1'b0; d_req = 1'b0;
        cyc("idle3", 3'b000);

        // halt masking holds the starvation count
        f_req = 1'b1; d_req = 1'b1;
        fd_run("pre_halt", "dd");
        halt = 1'b1;
        for (int i = 0; i < 10; i++) cyc("halt_mask", 3'b000);
        halt = 1'b0;
        fd_run("post_halt", "ddf");
        f_req = 1'b0; d_req = 1'b0;
        cyc("idle4", 3'b000);

        // reset one cycle after a granted data read
        f_req = 1'b1; d_req = 1'b1;
        fd_run("pre_reset", "dd");
        cyc("pre_reset", 3'b001);
        check("owed_rvalid", {31'd0, d_rvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_drop_rvalid", {29'd0, h_rvalid, f_rvalid, d_rvalid}, 32'd0);
        check("reset_drop_gnt", {29'd0, h_gnt, f_gnt, d_gnt}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("post_reset_rvalid", {29'd0, h_rvalid, f_rvalid, d_rvalid}, 32'd0);
        fd_run("post_reset", "ddddf");
        f_req = 1'b0; d_req = 1'b0;
        cyc("idle5", 3'b000);
        cyc("idle6", 3'b000);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/n1_mem_arbiter.md
# n1_mem_arbiter

Single-port arbiter for the n1 core's 16-bit program/data RAM. It shares one RAM port between three requesters:
- the host loader (program load and debug read-back),
- the instruction-fetch stage,
- the data load/store stage.

Each cycle it grants at most one access, using fixed priority plus a starvation guard for fetch. It routes the one-cycle-latency read data back to whichever requester issued the read.

## Interface
- RAM_WORDS, 128, RAM depth in 16-bit words; must be a power of two. AW = $clog2(RAM_WORDS).
- STARVE_LIMIT, 4, number of consecutive cycles fetch may be blocked by data before fetch wins over data; range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- halt  in  1  1 = fetch and data requests are masked; only host is served.
- h_req, f_req, d_req  in  1 each  access request, one per requester.
- h_we, d_we  in  1 each  1 = write, 0 = read. Fetch is read-only.
- h_addr, f_addr, d_addr  in  AW each  word address.
- h_wdata, d_wdata  in  16 each  write data.
- h_gnt, f_gnt, d_gnt  out  1 each  grant; combinational, at most one high.
- h_rvalid, f_rvalid, d_rvalid  out  1 each  read data valid on rdata; registered.
- rdata  out  16  read data; equals ram_rdata.
- ram_en  out  1  RAM access strobe (= OR of grants).
- ram_we  out  1  RAM write strobe.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  16  RAM write data.
- ram_rdata  in  16  RAM read data, valid the cycle after a read with ram_en=1.

## Operation
- Request rules:
  - A requester raises req with addr/we/wdata stable.
  - It keeps them stable until the cycle in which its gnt is high; the transfer happens in that cycle.
  - req may drop or change in the cycle after gnt.
- Arbitration order, evaluated each cycle on the current inputs:
  1. host;
  2. fetch, if starve_cnt == STARVE_LIMIT;
  3. data;
  4. fetch.
- While halt=1, f_req and d_req are treated as 0. starve_cnt holds its value during halt.
- The RAM mux forwards the granted requester's addr, we and wdata to the ram_* outputs. When there is no grant, ram_en=0, ram_we=0, and ram_addr/ram_wdata=0.
- starve_cnt is a 4-bit register:
  - +1 (saturating at STARVE_LIMIT) when f_req & !halt & d_gnt;
  - cleared when f_gnt or when f_req=0;
  - otherwise holds (including when host wins).
- Read-return tracking: a 2-bit owner register rsel is loaded every cycle with {host, fetch, data, none}, according to the granted read (gnt & !we).
  - Next cycle, the matching x_rvalid=1 and rdata = ram_rdata.
  - Writes produce no rvalid.
- Writes to an address read in the previous cycle need no special handling. The RAM returns the old word; this is a RAM property, not handled by the arbiter.

## Timing
- Reset (rst_n=0, asynchronous):
  - starve_cnt=0, rsel=none;
  - all x_rvalid=0.
  - Grants stay combinational but are forced 0 while rst_n=0.
- Grant latency: 0 cycles. gnt appears in the same cycle as req if that requester wins.
- Read latency: x_rvalid exactly 1 cycle after the granting edge. Back-to-back reads give a continuous rvalid stream, one per cycle.
- Throughput: one access per cycle, with no bubbles between different requesters.
- Fetch latency bound: with halt=0 and host idle, f_gnt occurs within STARVE_LIMIT+1 cycles of f_req rising.
- Reset mid-read: a pending rvalid is lost. After rst_n rises, rvalid outputs stay 0 until a new read is granted.
- halt rising while fetch/data are pending: masking takes effect in the same cycle. An rvalid already owed for the previous cycle's grant is still delivered.

## Test plan
- Host write then read:
  - Stimulus: halt=1; h_req, h_we=1, h_addr=5, h_wdata=16'h1A2B. Next cycle, h_we=0, same addr.
  - Response: h_gnt both cycles. h_rvalid=1 with rdata=16'h1A2B in the cycle after the read; f_gnt/d_gnt never high.
- Priority:
  - Stimulus: h_req, f_req and d_req all asserted with halt=0.
  - Response: h_gnt only. With host dropped, d_gnt only. With data also dropped, f_gnt.
- Starvation guard:
  - Stimulus: STARVE_LIMIT=4; f_req and d_req held high continuously.
  - Response: grant sequence d,d,d,d,f,d,d,d,d,f…; starve_cnt returns to 0 after each f_gnt.
- Read routing:
  - Stimulus: fetch read addr 0 (RAM holds 16'h1001), then data read addr 1 (holds 16'h2002) on consecutive cycles.
  - Response: f_rvalid with rdata=16'h1001, then d_rvalid with rdata=16'h2002, on consecutive cycles; never both rvalids high.
- Reset mid-operation:
  - Stimulus: drop rst_n asynchronously one cycle after a granted data read.
  - Response: d_rvalid drops immediately, all gnt=0 and starve_cnt=0. After release, the first grant follows the normal priority order.
- halt masking:
  - Stimulus: halt=1 with f_req=1 and d_req=1 for 10 cycles.
  - Response: no f_gnt/d_gnt and starve_cnt unchanged. After halt=0, d_gnt in the first cycle.
